// File: rtl/bus_stall_memory_pkg.sv
// Shared types and helpers for the bus_stall_memory slave: bank base addresses,
// controller state encoding and the byte-lane write merge.
package bus_stall_memory_pkg;

  localparam logic [31:0] BOOT_BASE = 32'hBFC0_0000;
  localparam logic [31:0] DATA_BASE = 32'h0000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byte_en);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bus_stall_ctrl.sv
// Wait-state controller: holds waitrequest for num_stalls cycles (sampled on the
// first request cycle) and flags the completion cycle of each transaction.
module bus_stall_ctrl
  import bus_stall_memory_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] num_stalls,
  output logic       waitrequest,
  output logic       complete
);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    waitrequest = 1'b0;
    complete    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (num_stalls == 4'd0) begin
            complete = 1'b1;
          end else begin
            waitrequest = 1'b1;
            cnt_n       = num_stalls - 4'd1;
            state_n     = STALL;
          end
        end
      end
      STALL: begin
        if (!req) begin
          state_n = IDLE;              // master gave up: abort, no memory effect
        end else if (cnt != 4'd0) begin
          waitrequest = 1'b1;
          cnt_n       = cnt - 4'd1;
        end else begin
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // While reset is held the outputs must read as an idle, inert slave.
    if (!reset) begin
      waitrequest = 1'b0;
      complete    = 1'b0;
    end
  end

endmodule

// File: rtl/bus_stall_memory.sv
// Avalon-MM style memory slave with a boot bank at the MIPS reset vector and a
// data bank at address 0. Optional trace output under `ifdef BUS_MEM_TRACE_EN.
module bus_stall_memory
  import bus_stall_memory_pkg::*;
#(
  parameter string INIT_FILE  = "",
  parameter int    BOOT_WORDS = 1024,
  parameter int    DATA_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  num_stalls,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata
);

  localparam int          BOOT_AW    = $clog2(BOOT_WORDS);
  localparam int          DATA_AW    = $clog2(DATA_WORDS);
  localparam logic [31:0] BOOT_BYTES = 32'(BOOT_WORDS * 4);
  localparam logic [31:0] DATA_BYTES = 32'(DATA_WORDS * 4);

  logic               complete;
  logic [31:0]        boot_off, data_off;
  logic               boot_hit, data_hit;
  logic [BOOT_AW-1:0] boot_idx;
  logic [DATA_AW-1:0] data_idx;
  logic [31:0]        rd_word;
  logic               unused_lsbs;

  logic [31:0] boot_mem [BOOT_WORDS];
  logic [31:0] data_mem [DATA_WORDS];

  bus_stall_ctrl u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .req         (read | write),
    .num_stalls  (num_stalls),
    .waitrequest (waitrequest),
    .complete    (complete)
  );

  // Unsigned offset compare: addresses below a base wrap to huge offsets and miss.
  assign boot_off    = address - BOOT_BASE;
  assign data_off    = address - DATA_BASE;
  assign boot_hit    = boot_off < BOOT_BYTES;
  assign data_hit    = data_off < DATA_BYTES;
  assign boot_idx    = boot_off[BOOT_AW+1:2];
  assign data_idx    = data_off[DATA_AW+1:2];
  assign unused_lsbs = ^{boot_off[1:0], data_off[1:0]};

  initial begin
    for (int i = 0; i < BOOT_WORDS; i++) boot_mem[i] = '0;
    for (int i = 0; i < DATA_WORDS; i++) data_mem[i] = '0;
  end

  // NOTE: the banks are deliberately left out of reset so contents survive
  // a reset pulse; only the controller registers are reset.
  always_ff @(posedge clk) begin
    if (complete && write) begin
      if (boot_hit) boot_mem[boot_idx] <= merge_bytes(boot_mem[boot_idx], writedata, byteenable);
      if (data_hit) data_mem[data_idx] <= merge_bytes(data_mem[data_idx], writedata, byteenable);
    end
  end

  always_comb begin
    rd_word = '0;
    if (boot_hit)      rd_word = boot_mem[boot_idx];
    else if (data_hit) rd_word = data_mem[data_idx];
  end

  // A simultaneous read+write is a write, so it never returns data.
  assign readdata = (complete && read && !write) ? rd_word : '0;

`ifdef BUS_MEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (complete) begin
      $display("[bus_mem] %0t %s addr=%08h be=%04b data=%08h", $time,
               write ? "W" : "R", address, byteenable, write ? writedata : rd_word);
      if (!boot_hit && !data_hit)
        $display("[bus_mem] %0t warning: unmapped access at %08h", $time, address);
    end
  end
`endif

endmodule

// File: tb/tb_bus_stall_memory.sv
// Randomized self-checking bench for bus_stall_memory against a flat-array
// reference model of both banks and the wait-state latency rule.
module tb_bus_stall_memory;

  localparam int          BOOT_WORDS = 64;
  localparam int          DATA_WORDS = 256;
  localparam logic [31:0] BOOT_BASE  = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [3:0]  num_stalls;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_boot [BOOT_WORDS];
  logic [31:0] model_data [DATA_WORDS];

  bus_stall_memory #(
    .INIT_FILE  (""),
    .BOOT_WORDS (BOOT_WORDS),
    .DATA_WORDS (DATA_WORDS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .write       (write),
    .read        (read),
    .num_stalls  (num_stalls),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= BOOT_BASE && a < BOOT_BASE + BOOT_WORDS * 4) return model_boot[(a - BOOT_BASE) / 4];
    if (a < DATA_WORDS * 4) return model_data[a / 4];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = model_read(a);
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    if (a >= BOOT_BASE && a < BOOT_BASE + BOOT_WORDS * 4) model_boot[(a - BOOT_BASE) / 4] = w;
    else if (a < DATA_WORDS * 4) model_data[a / 4] = w;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    read = 1'b0; write = 1'b0; num_stalls = 4'($urandom);
    #1;
    check("idle_wait", {31'b0, waitrequest}, 32'h0);
    check("idle_rdata", readdata, 32'h0);
  endtask

  // One transaction: n wait cycles, then completion; abort_at in 1..n drops the
  // request in that cycle instead (negative means no abort).
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input int n, input int abort_at);
    logic [31:0] exp_rd;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        read = 1'b0; write = 1'b0;
        #1;
        check("abort_wait", {31'b0, waitrequest}, 32'h0);
        check("abort_rdata", readdata, 32'h0);
        return;
      end
      read = rd; write = wr; address = a; writedata = d; byteenable = be;
      num_stalls = (c == 0) ? 4'(n) : 4'($urandom);
      #1;
      if (c < n) begin
        check("stall_wait", {31'b0, waitrequest}, 32'h1);
        check("stall_rdata", readdata, 32'h0);
      end else begin
        exp_rd = (rd && !wr) ? model_read(a) : 32'h0;
        check("done_wait", {31'b0, waitrequest}, 32'h0);
        check("done_rdata", readdata, exp_rd);
        if (wr) model_write(a, d, be);
      end
    end
  endtask

  logic [31:0] edge_addr [6];

  initial begin
    int r, n, ab;
    logic [31:0] a;
    logic rd, wr;

    for (int i = 0; i < BOOT_WORDS; i++) model_boot[i] = '0;
    for (int i = 0; i < DATA_WORDS; i++) model_data[i] = '0;
    edge_addr[0] = BOOT_BASE - 4;
    edge_addr[1] = BOOT_BASE + BOOT_WORDS * 4;
    edge_addr[2] = DATA_WORDS * 4;
    edge_addr[3] = 32'h8000_0000;
    edge_addr[4] = 32'hFFFF_FFFC;
    edge_addr[5] = BOOT_BASE + BOOT_WORDS * 4 - 4;

    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; byteenable = '0; num_stalls = '0;
    #1;
    check("reset_wait", {31'b0, waitrequest}, 32'h0);
    check("reset_rdata", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_cycle();

    // Boot word written then read with zero and five stalls.
    do_txn(1'b0, 1'b1, BOOT_BASE, 32'h3C02_1234, 4'hF, 0, -1);
    do_txn(1'b1, 1'b0, BOOT_BASE, 32'h0, 4'h0, 0, -1);
    do_txn(1'b0, 1'b1, BOOT_BASE + 4, 32'h2442_5678, 4'hF, 2, -1);
    do_txn(1'b1, 1'b0, BOOT_BASE + 4, 32'h0, 4'h0, 5, -1);

    // Partial-lane write over zero.
    do_txn(1'b0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 3, -1);
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, -1);
    check("lane_merge", model_read(32'h10), 32'h00BB_00DD);

    // Abort a long stall, then a normal write completes.
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 13, 4);
    do_txn(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 1, -1);
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, -1);

    // Unmapped: write dropped, read returns 0; byteenable=0 is a no-op.
    do_txn(1'b0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 2, -1);
    do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1, -1);
    do_txn(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, -1);
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, -1);
    do_txn(1'b1, 1'b1, 32'h24, 32'h0BAD_F00D, 4'hF, 0, -1);
    do_txn(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 0, -1);

    // Reset mid-stall of a write: outputs drop at once, nothing commits.
    @(negedge clk);
    read = 1'b0; write = 1'b1; address = 32'h20; writedata = 32'h5555_5555;
    byteenable = 4'hF; num_stalls = 4'd6;
    #1;
    check("rst_pre_wait", {31'b0, waitrequest}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wait", {31'b0, waitrequest}, 32'h0);
    check("rst_rdata", readdata, 32'h0);
    @(negedge clk);
    read = 1'b1; write = 1'b0; num_stalls = 4'd0;
    #1;
    check("rst_read_wait", {31'b0, waitrequest}, 32'h0);
    check("rst_read_rdata", readdata, 32'h0);
    @(negedge clk);
    read = 1'b0;
    reset = 1'b1;
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, -1);
    do_txn(1'b1, 1'b0, BOOT_BASE, 32'h0, 4'h0, 3, -1);

    // Randomized back-to-back traffic, with occasional idles and aborts.
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 7);
      if (r < 3)      a = BOOT_BASE + ($urandom_range(0, BOOT_WORDS - 1) * 4) + $urandom_range(0, 3);
      else if (r < 6) a = ($urandom_range(0, DATA_WORDS - 1) * 4) + $urandom_range(0, 3);
      else            a = edge_addr[$urandom_range(0, 5)];
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      n  = $urandom_range(0, 15);
      ab = (n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, n) : -1;
      do_txn(rd, wr, a, $urandom, 4'($urandom), n, ab);
      if ($urandom_range(0, 5) == 0) idle_cycle();
    end

    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
